// File: rtl/riscv_pkg.sv
// Shared trace packet layout and controller state encoding.
// Pure declarations: no logic, no latency, no flow control.
package riscv_pkg;

  localparam logic [7:0] PKT_HDR  = 8'hA5;
  localparam int         PKT_LEN  = 22;
  localparam int         IDX_W    = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] PKT_LAST = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } trc_state_e;

  // Header sits in the least significant byte so byte i of the packet is bits [8*i +: 8].
  typedef struct packed {
    logic [63:0] rddata;
    logic [7:0]  rd;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [7:0]  hdr;
  } pkt_t;

  function automatic pkt_t build_pkt(input logic [63:0] f_pc, input logic [31:0] f_inst,
                                     input logic [7:0] f_rd, input logic [63:0] f_data);
    pkt_t p;
    p.hdr    = PKT_HDR;
    p.pc     = f_pc;
    p.inst   = f_inst;
    p.rd     = f_rd;
    p.rddata = f_data;
    return p;
  endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Record FIFO, DEPTH entries; pushed data readable at the head the next cycle, head is combinational.
// Push while full is only taken when a pop happens in the same cycle; pop on empty is ignored.
module riscv_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_riscv_clk,
  input  logic             i_riscv_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // The extra MSB distinguishes full from empty when the index bits coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_riscv_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/riscv_trace_ctrl.sv
// Captures retired-instruction records and streams each as a 22-byte packet; header valid 2 cycles after capture.
// txready stalls the byte stream with txdata held; records arriving at a full FIFO are dropped and counted.
module riscv_trace_ctrl
  import riscv_pkg::*;
#(
  parameter int dwidth = 64,
  parameter int iwidth = 32,
  parameter int awidth = 5,
  parameter int DEPTH  = 4
) (
  input  logic              i_riscv_clk,
  input  logic              i_riscv_rst,
  input  logic              i_riscv_trc_en,
  input  logic              i_riscv_trc_valid,
  input  logic [dwidth-1:0] i_riscv_trc_pc,
  input  logic [iwidth-1:0] i_riscv_trc_inst,
  input  logic [awidth-1:0] i_riscv_trc_rdaddr,
  input  logic [dwidth-1:0] i_riscv_trc_rddata,
  output logic [7:0]        o_riscv_trc_txdata,
  output logic              o_riscv_trc_txvalid,
  input  logic              i_riscv_trc_txready,
  output logic              o_riscv_trc_full,
  output logic [15:0]       o_riscv_trc_drop
);

  localparam int RECW = 2*dwidth + iwidth + awidth;

  trc_state_e               state;
  trc_state_e               state_nxt;
  logic [IDX_W-1:0]         byte_idx;
  pkt_t                     pkt;
  logic [PKT_LEN-1:0][7:0]  pkt_b;
  logic [15:0]              drop_cnt;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     push;
  logic                     cap_req;
  logic                     tx_acc;
  logic [RECW-1:0]          rec_in;
  logic [RECW-1:0]          rec_out;
  logic [dwidth-1:0]        h_pc;
  logic [iwidth-1:0]        h_inst;
  logic [awidth-1:0]        h_rd;
  logic [dwidth-1:0]        h_data;

  assign cap_req = i_riscv_trc_valid && i_riscv_trc_en;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = cap_req && (!fifo_full || pop);
  assign rec_in  = {i_riscv_trc_pc, i_riscv_trc_inst, i_riscv_trc_rdaddr, i_riscv_trc_rddata};
  assign {h_pc, h_inst, h_rd, h_data} = rec_out;

  riscv_trace_fifo #(
    .WIDTH (RECW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_riscv_clk (i_riscv_clk),
    .i_riscv_rst (i_riscv_rst),
    .push        (push),
    .push_dat    (rec_in),
    .pop         (pop),
    .pop_dat     (rec_out),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign o_riscv_trc_txvalid = (state == SEND);
  assign tx_acc              = o_riscv_trc_txvalid && i_riscv_trc_txready;
  assign pkt_b               = pkt;
  assign o_riscv_trc_txdata  = (state == SEND) ? pkt_b[byte_idx] : 8'h00;
  assign o_riscv_trc_full    = fifo_full;
  assign o_riscv_trc_drop    = drop_cnt;

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) state_nxt = LOAD;
      LOAD: begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (tx_acc && byte_idx == PKT_LAST) state_nxt = fifo_empty ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      byte_idx <= '0;
    end else if (state == LOAD) begin
      byte_idx <= '0;
    end else if (tx_acc) begin
      byte_idx <= (byte_idx == PKT_LAST) ? '0 : byte_idx + IDX_W'(1);
    end
  end

  // Payload only matters in SEND; txdata is forced to zero elsewhere, so no reset here.
  always_ff @(posedge i_riscv_clk) begin
    if (state == LOAD) pkt <= build_pkt(64'(h_pc), 32'(h_inst), 8'(h_rd), 64'(h_data));
  end

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      drop_cnt <= 16'h0000;
    end else if (cap_req && fifo_full && !pop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_riscv_trace_ctrl.sv
// Scoreboard bench for riscv_trace_ctrl: expected packet bytes are queued as records are driven
// and checked byte by byte as the controller hands them to the transmitter.
`timescale 1ns/1ps
module tb_riscv_trace_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        vld = 1'b0;
  logic        rdy = 1'b0;
  logic [63:0] pc  = '0;
  logic [31:0] inst = '0;
  logic [4:0]  rd  = '0;
  logic [63:0] data = '0;
  logic [7:0]  txdata;
  logic        txvalid;
  logic        full;
  logic [15:0] drop;

  always #5 clk = ~clk;

  riscv_trace_ctrl dut (
    .i_riscv_clk         (clk),
    .i_riscv_rst         (rst),
    .i_riscv_trc_en      (en),
    .i_riscv_trc_valid   (vld),
    .i_riscv_trc_pc      (pc),
    .i_riscv_trc_inst    (inst),
    .i_riscv_trc_rdaddr  (rd),
    .i_riscv_trc_rddata  (data),
    .o_riscv_trc_txdata  (txdata),
    .o_riscv_trc_txvalid (txvalid),
    .i_riscv_trc_txready (rdy),
    .o_riscv_trc_full    (full),
    .o_riscv_trc_drop    (drop)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          exp_drop = 0;
  logic [7:0]  exp_q [$];
  int          gap_q [$];
  int          mon_idx = 0;
  int          pkts = 0;
  int          last_cyc = 0;
  bit          have_last = 1'b0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [7:0]  pd = 8'h00;

  logic [7:0] lit_pkt [22] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h00, 8'h10, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00};

  always @(posedge clk) cyc <= cyc + 1;

  // Byte monitor: scoreboard compare, hold-while-stalled check, gap between packets.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      mon_idx   = 0;
      have_last = 1'b0;
      pv        = 1'b0;
    end else begin
      if (txvalid && !pv && have_last) gap_q.push_back(cyc - last_cyc);
      if (pv && !pr && txvalid) begin
        total++;
        if (txdata !== pd) begin
          bad++;
          $display("FAIL hold: txdata=%h required %h", txdata, pd);
        end
      end
      if (txvalid && rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: txdata=%h with empty scoreboard", txdata);
        end else begin
          e = exp_q.pop_front();
          if (txdata !== e) begin
            bad++;
            $display("FAIL byte%0d: txdata=%h required %h", mon_idx, txdata, e);
          end
        end
        if (mon_idx == 21) begin
          mon_idx   = 0;
          pkts++;
          last_cyc  = cyc;
          have_last = 1'b1;
        end else begin
          mon_idx++;
        end
      end
      pv = txvalid;
      pr = rdy;
      pd = txdata;
    end
  end

  task automatic push_exp(input logic [63:0] p, input logic [31:0] i, input logic [4:0] r,
                          input logic [63:0] d);
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 8; k++) exp_q.push_back(p[8*k +: 8]);
    for (int k = 0; k < 4; k++) exp_q.push_back(i[8*k +: 8]);
    exp_q.push_back({3'b000, r});
    for (int k = 0; k < 8; k++) exp_q.push_back(d[8*k +: 8]);
  endtask

  task automatic drive_rec(input logic [63:0] p, input logic [31:0] i, input logic [4:0] r,
                           input logic [63:0] d);
    @(posedge clk); #1;
    vld = 1'b1; pc = p; inst = i; rd = r; data = d;
  endtask

  task automatic end_rec();
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic wait_header(input int limit);
    int n = 0;
    @(negedge clk);
    while (!txvalid && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!txvalid) begin
      bad++;
      $display("FAIL header_timeout: txvalid=%b required 1 within %0d cycles", txvalid, limit);
    end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || txvalid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || txvalid) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d txvalid=%b required 0/0", exp_q.size(), txvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; vld = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    total += 4;
    if (txvalid !== 1'b0) begin bad++; $display("FAIL reset_txvalid: got %b required 0", txvalid); end
    if (txdata !== 8'h00) begin bad++; $display("FAIL reset_txdata: got %h required 00", txdata); end
    if (full !== 1'b0)    begin bad++; $display("FAIL reset_full: got %b required 0", full); end
    if (drop !== 16'h0)   begin bad++; $display("FAIL reset_drop: got %0d required 0", drop); end
  endtask

  task automatic test_single();
    int p0;
    rdy = 1'b1;
    p0 = pkts;
    for (int k = 0; k < 22; k++) exp_q.push_back(lit_pkt[k]);
    drive_rec(64'h0000_0000_8000_0000, 32'h0010_0093, 5'd1, 64'd1);
    @(posedge clk); #1;  // capture edge N
    vld = 1'b0;
    @(negedge clk);
    total++;
    if (txvalid !== 1'b0) begin bad++; $display("FAIL lat_n1: txvalid=%b required 0", txvalid); end
    @(negedge clk);
    total++;
    if (txvalid !== 1'b0) begin bad++; $display("FAIL lat_n2_load: txvalid=%b required 0", txvalid); end
    @(negedge clk);
    total++;
    if (txvalid !== 1'b1 || txdata !== 8'hA5) begin
      bad++;
      $display("FAIL lat_first: txvalid=%b txdata=%h required 1/a5", txvalid, txdata);
    end
    wait_drain(100);
    repeat (3) @(negedge clk);
    total += 2;
    if (txvalid !== 1'b0) begin bad++; $display("FAIL single_idle: txvalid=%b required 0", txvalid); end
    if (pkts - p0 != 1) begin bad++; $display("FAIL single_count: packets=%0d required 1", pkts - p0); end
  endtask

  task automatic test_stall();
    logic [63:0] p = 64'h0123_4567_89AB_CDEF;
    logic [7:0]  hold;
    int          p0 = pkts;
    rdy = 1'b1;
    push_exp(p, 32'hDEAD_BEEF, 5'd17, 64'hFEDC_BA98_7654_3210);
    drive_rec(p, 32'hDEAD_BEEF, 5'd17, 64'hFEDC_BA98_7654_3210);
    end_rec();
    wait_header(10);
    repeat (3) begin @(posedge clk); #1; end
    rdy = 1'b0;  // byte 3 on the bus
    @(negedge clk);
    hold = txdata;
    total++;
    if (txdata !== p[23:16]) begin bad++; $display("FAIL stall_byte3: txdata=%h required %h", txdata, p[23:16]); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (txvalid !== 1'b1 || txdata !== hold) begin
      bad++;
      $display("FAIL stall_held: txvalid=%b txdata=%h required 1/%h", txvalid, txdata, hold);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_drain(100);
    total++;
    if (pkts - p0 != 1) begin bad++; $display("FAIL stall_count: packets=%0d required 1", pkts - p0); end
  endtask

  // Leaves one packet stalled at its header and the FIFO full with four more records.
  task automatic fill_stalled(input logic [31:0] tag, input int extra);
    rdy = 1'b0;
    push_exp({32'h0, tag}, tag, 5'd3, {tag, tag});
    drive_rec({32'h0, tag}, tag, 5'd3, {tag, tag});
    end_rec();
    wait_header(10);
    for (int k = 1; k <= 4 + extra; k++) begin
      if (k <= 4) push_exp({32'h0, tag + k}, tag + k, 5'(k), {tag, tag + k});
      drive_rec({32'h0, tag + k}, tag + k, 5'(k), {tag, tag + k});
    end
    end_rec();
    exp_drop += extra;
  endtask

  task automatic test_overflow();
    int p0;
    fill_stalled(32'h1000_0000, 2);
    @(negedge clk);
    total += 2;
    if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b required 1", full); end
    if (drop !== 16'(exp_drop)) begin bad++; $display("FAIL ovf_drop: got %0d required %0d", drop, exp_drop); end
    gap_q.delete();
    p0 = pkts;
    @(posedge clk); #1;
    rdy = 1'b1;
    wait_drain(400);
    total += 4;
    if (pkts - p0 != 5) begin bad++; $display("FAIL ovf_count: packets=%0d required 5", pkts - p0); end
    if (gap_q.size() != 4) begin bad++; $display("FAIL ovf_gaps: got %0d gaps required 4", gap_q.size()); end
    if (full !== 1'b0) begin bad++; $display("FAIL ovf_after_full: got %b required 0", full); end
    if (drop !== 16'(exp_drop)) begin bad++; $display("FAIL ovf_after_drop: got %0d required %0d", drop, exp_drop); end
    foreach (gap_q[k]) begin
      total++;
      if (gap_q[k] != 2) begin bad++; $display("FAIL ovf_load_gap%0d: got %0d cycles required 2", k, gap_q[k]); end
    end
  endtask

  task automatic test_full_pop_push();
    fill_stalled(32'h2000_0000, 0);
    @(negedge clk);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL fpp_full_before: got %b required 1", full); end
    @(posedge clk); #1;
    rdy = 1'b1;
    repeat (22) @(posedge clk);
    #1;  // LOAD cycle of the next packet
    push_exp(64'h55, 32'h0000_0055, 5'd31, 64'h5555);
    vld = 1'b1; pc = 64'h55; inst = 32'h0000_0055; rd = 5'd31; data = 64'h5555;
    @(posedge clk); #1;
    vld = 1'b0;
    @(negedge clk);
    total += 2;
    if (full !== 1'b1) begin bad++; $display("FAIL fpp_full_after: got %b required 1", full); end
    if (drop !== 16'(exp_drop)) begin bad++; $display("FAIL fpp_drop: got %0d required %0d", drop, exp_drop); end
    wait_drain(400);
  endtask

  task automatic test_reset_mid();
    rdy = 1'b1;
    push_exp(64'hAAAA_0000, 32'h1111_2222, 5'd7, 64'h3333);
    drive_rec(64'hAAAA_0000, 32'h1111_2222, 5'd7, 64'h3333);
    end_rec();
    wait_header(10);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;  // byte 10 on the bus; valid during reset must be ignored
    vld = 1'b1; pc = 64'h77; inst = 32'h77; rd = 5'd7; data = 64'h77;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; vld = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    total += 4;
    if (txvalid !== 1'b0) begin bad++; $display("FAIL rstmid_txvalid: got %b required 0", txvalid); end
    if (txdata !== 8'h00) begin bad++; $display("FAIL rstmid_txdata: got %h required 00", txdata); end
    if (drop !== 16'h0)   begin bad++; $display("FAIL rstmid_drop: got %0d required 0", drop); end
    if (full !== 1'b0)    begin bad++; $display("FAIL rstmid_full: got %b required 0", full); end
    repeat (4) @(negedge clk);
    total++;
    if (txvalid !== 1'b0) begin bad++; $display("FAIL rstmid_ignored: txvalid=%b required 0", txvalid); end
    push_exp(64'hBBBB_0001, 32'h4444_5555, 5'd9, 64'h6666);
    drive_rec(64'hBBBB_0001, 32'h4444_5555, 5'd9, 64'h6666);
    end_rec();
    wait_drain(100);
  endtask

  task automatic test_en_off();
    int p0 = pkts;
    rdy = 1'b1;
    push_exp(64'hC0DE, 32'hCAFE_F00D, 5'd12, 64'h1234);
    drive_rec(64'hC0DE, 32'hCAFE_F00D, 5'd12, 64'h1234);
    end_rec();
    wait_header(10);
    @(posedge clk); #1;
    en = 1'b0; vld = 1'b1; pc = 64'h99; inst = 32'h99; rd = 5'd2; data = 64'h99;
    repeat (5) @(posedge clk);
    #1 vld = 1'b0; en = 1'b1;
    wait_drain(100);
    repeat (4) @(negedge clk);
    total += 4;
    if (drop !== 16'(exp_drop)) begin bad++; $display("FAIL enoff_drop: got %0d required %0d", drop, exp_drop); end
    if (full !== 1'b0) begin bad++; $display("FAIL enoff_full: got %b required 0", full); end
    if (txvalid !== 1'b0) begin bad++; $display("FAIL enoff_idle: txvalid=%b required 0", txvalid); end
    if (pkts - p0 != 1) begin bad++; $display("FAIL enoff_count: packets=%0d required 1", pkts - p0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    test_en_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
